// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl -- MEM-stage load/store sequencer.
//
// Splits one byte/half/word access into beats of BEAT_BYTES bytes on the
// external bus, tracks returning read data against a fixed READ_LAT,
// assembles it little-endian and sign/zero-extends the load result.
// Raises busy_o while the access is in flight and pulses done_o once.
//
// Optional build macro: MEM_ALIGN_CHECK_EN -- when defined, misaligned
// half/word accesses issue no beats and finish in cycle 1 with err_o=1.
//
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   req_i, we_i, sel_i,    access request, store flag, size (00 b, 01 h,
//   sign_i, addr_i,        10 w, 11 reserved), sign-extend flag, byte
//   wdata_i                address, store data (byte 0 -> addr_i)
//   busy_o, done_o,        stall request, completion pulse,
//   rdata_o, err_o         extended load result, misalignment flag
//   mem_addr_o, mem_we_o,  beat address, write strobe,
//   mem_be_o, mem_wdata_o, lane enables, write data,
//   mem_rdata_i            read data (valid READ_LAT cycles after issue)
module mem_access_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int BEAT_BYTES = 1,
  parameter int READ_LAT   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [1:0]              sel_i,
  input  logic                    sign_i,
  input  logic [ADDR_W-1:0]       addr_i,
  input  logic [31:0]             wdata_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [31:0]             rdata_o,
  output logic                    err_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic                    mem_we_o,
  output logic [BEAT_BYTES-1:0]   mem_be_o,
  output logic [8*BEAT_BYTES-1:0] mem_wdata_o,
  input  logic [8*BEAT_BYTES-1:0] mem_rdata_i
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                         state_q, state_d;
  logic [ADDR_W-1:0]              addr_q;
  logic [1:0]                     sel_q;
  logic                           we_q, sign_q, err_q;
  logic [3:0][7:0]                wdata_q;
  logic [3:0][7:0]                asm_q;   // byte-assembly register
  logic [CNT_W-1:0]               beat_q;
  logic [READ_LAT-1:0]            vld_q;   // in-flight read beat tags
  logic [READ_LAT-1:0][CNT_W-1:0] tag_q;

  logic [2:0]       size;
  logic [CNT_W-1:0] last_beat;
  logic             misalign, skip, issue_rd, cap_last;
  int               lane_base, cap_base;
  logic [31:0]      ext;

  // Acceptance-time decode of the incoming request.
`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = ((sel_i == 2'b01) && addr_i[0]) ||
                    ((sel_i == 2'b10) && (addr_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif
  assign skip = (sel_i == 2'b11) || misalign;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    size = 3'd0;
    case (sel_q)
      2'b00:   size = 3'd1;
      2'b01:   size = 3'd2;
      2'b10:   size = 3'd4;
      default: size = 3'd0;
    endcase
    // Reserved size yields an out-of-range value here, but never reaches ISSUE.
    last_beat = CNT_W'((int'(size) + BEAT_BYTES - 1) / BEAT_BYTES - 1);
    lane_base = int'(beat_q) * BEAT_BYTES;
    cap_base  = int'(tag_q[READ_LAT-1]) * BEAT_BYTES;
  end

  assign issue_rd = (state_q == S_ISSUE) && !we_q;
  assign cap_last = (state_q == S_DRAIN) && vld_q[READ_LAT-1] &&
                    (tag_q[READ_LAT-1] == last_beat);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_i) state_d = skip ? S_DONE : S_ISSUE;
      S_ISSUE: if (beat_q == last_beat) state_d = we_q ? S_DONE : S_DRAIN;
      S_DRAIN: if (cap_last) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Load extension of the assembled bytes; reserved/misaligned give 0
  // because the assembly register is cleared on acceptance.
  always_comb begin
    ext = 32'd0;
    case (sel_q)
      2'b00:   ext = {{24{sign_q & asm_q[0][7]}}, asm_q[0]};
      2'b01:   ext = {{16{sign_q & asm_q[1][7]}}, asm_q[1], asm_q[0]};
      2'b10:   ext = asm_q;
      default: ext = 32'd0;
    endcase
  end

  // Outputs: the bus is driven only in ISSUE, so it reads zero elsewhere.
  always_comb begin
    done_o      = (state_q == S_DONE);
    rdata_o     = done_o ? ext : 32'd0;
    err_o       = done_o & err_q;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (state_q == S_ISSUE) begin
      mem_addr_o = addr_q + ADDR_W'(lane_base);
      mem_we_o   = we_q;
      for (int k = 0; k < BEAT_BYTES; k++) begin
        if (lane_base + k < int'(size)) begin
          mem_be_o[k] = 1'b1;
          if (we_q) mem_wdata_o[8*k +: 8] = wdata_q[2'(lane_base + k)];
        end
      end
    end
  end

  assign busy_o = req_i & ~done_o;

  // Datapath: request latch, beat counter, read tag pipeline, assembly.
  // NOTE: the assembly register is reset along with the control state so a
  // mid-access reset cannot leak stale bytes into a later result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      sel_q   <= 2'b00;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      asm_q   <= '0;
      beat_q  <= '0;
      vld_q   <= '0;
      tag_q   <= '0;
    end else begin
      vld_q[0] <= issue_rd;
      tag_q[0] <= beat_q;
      for (int k = 1; k < READ_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        tag_q[k] <= tag_q[k-1];
      end

      if (vld_q[READ_LAT-1]) begin
        for (int k = 0; k < BEAT_BYTES; k++) begin
          if (cap_base + k < 4) asm_q[2'(cap_base + k)] <= mem_rdata_i[8*k +: 8];
        end
      end

      if (state_q == S_IDLE && req_i) begin
        addr_q  <= addr_i;
        sel_q   <= sel_i;
        we_q    <= we_i;
        sign_q  <= sign_i;
        err_q   <= misalign;
        wdata_q <= wdata_i;
        asm_q   <= '0;
        beat_q  <= '0;
      end else if (state_q == S_ISSUE) begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  localparam int BB  = 1;
  localparam int RL  = 2;
  localparam int BB2 = 4;
  localparam int RL2 = 3;
  localparam int DW  = 8 * BB;
  localparam int DW2 = 8 * BB2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 1: BEAT_BYTES=1, READ_LAT=2
  logic          req, we, sign, busy, done, err, m_we;
  logic [1:0]    sel;
  logic [31:0]   addr, wdata, rdata, m_addr;
  logic [BB-1:0] m_be;
  logic [DW-1:0] m_wdata, m_rdata;

  // Instance 2: BEAT_BYTES=4, READ_LAT=3
  logic           req2, we2, sign2, busy2, done2, err2, m_we2;
  logic [1:0]     sel2;
  logic [31:0]    addr2, wdata2, rdata2, m_addr2;
  logic [BB2-1:0] m_be2;
  logic [DW2-1:0] m_wdata2, m_rdata2;

  mem_access_ctrl #(.ADDR_W(32), .BEAT_BYTES(BB), .READ_LAT(RL)) u_dut (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we), .sel_i(sel), .sign_i(sign),
    .addr_i(addr), .wdata_i(wdata), .busy_o(busy), .done_o(done),
    .rdata_o(rdata), .err_o(err), .mem_addr_o(m_addr), .mem_we_o(m_we),
    .mem_be_o(m_be), .mem_wdata_o(m_wdata), .mem_rdata_i(m_rdata)
  );

  mem_access_ctrl #(.ADDR_W(32), .BEAT_BYTES(BB2), .READ_LAT(RL2)) u_dut2 (
    .clk(clk), .rst(rst), .req_i(req2), .we_i(we2), .sel_i(sel2), .sign_i(sign2),
    .addr_i(addr2), .wdata_i(wdata2), .busy_o(busy2), .done_o(done2),
    .rdata_o(rdata2), .err_o(err2), .mem_addr_o(m_addr2), .mem_we_o(m_we2),
    .mem_be_o(m_be2), .mem_wdata_o(m_wdata2), .mem_rdata_i(m_rdata2)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference memory (spec-level view) and bus-side memories seen by the DUTs.
  logic [7:0] ref_mem  [1024];
  logic [7:0] bus_mem  [1024];
  logic [7:0] bus_mem2 [1024];

  // Bus responder 1: writes on strobe, returns read beats RL cycles later.
  logic        pv  [RL+1];
  logic [31:0] pa  [RL+1];
  always @(negedge clk) begin
    if (m_we) for (int k = 0; k < BB; k++) if (m_be[k]) bus_mem[10'(m_addr + k)] = m_wdata[8*k +: 8];
    for (int s = RL; s > 0; s--) begin pv[s] = pv[s-1]; pa[s] = pa[s-1]; end
    pv[0] = (m_be != '0) && !m_we;
    pa[0] = m_addr;
    if (pv[RL]) for (int k = 0; k < BB; k++) m_rdata[8*k +: 8] = bus_mem[10'(pa[RL] + k)];
    else        m_rdata = DW'($urandom);
  end

  // Bus responder 2.
  logic        pv2 [RL2+1];
  logic [31:0] pa2 [RL2+1];
  always @(negedge clk) begin
    if (m_we2) for (int k = 0; k < BB2; k++) if (m_be2[k]) bus_mem2[10'(m_addr2 + k)] = m_wdata2[8*k +: 8];
    for (int s = RL2; s > 0; s--) begin pv2[s] = pv2[s-1]; pa2[s] = pa2[s-1]; end
    pv2[0] = (m_be2 != '0) && !m_we2;
    pa2[0] = m_addr2;
    if (pv2[RL2]) for (int k = 0; k < BB2; k++) m_rdata2[8*k +: 8] = bus_mem2[10'(pa2[RL2] + k)];
    else          m_rdata2 = DW2'($urandom);
  end

  function automatic int size_of(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : (s == 2'd2) ? 4 : 0;
  endfunction

  // One access on instance 1, checked cycle by cycle against the spec rules.
  // Leaves req high after done; the caller either starts the next access or idles.
  task automatic access(input logic w, input logic [1:0] s, input logic sg,
                        input logic [31:0] a, input logic [31:0] d);
    int size, nb, exp_done, idx;
    logic mis, skip, got_done;
    longint v;
    logic [31:0] exp_r;
    logic [BB-1:0] ebe;
    logic [DW-1:0] ewd, mask;
    size = size_of(s);
    mis  = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00);
`endif
    skip     = (s == 2'd3) || mis;
    nb       = skip ? 0 : (size + BB - 1) / BB;
    exp_done = skip ? 1 : (w ? nb + 1 : nb + RL + 1);
    v = 0;
    if (!skip && !w) begin
      for (int i = 0; i < size; i++) v += longint'(ref_mem[10'(a + i)]) << (8 * i);
      if (sg && v[8*size-1]) v -= (64'sd1 << (8 * size));
    end
    exp_r = v[31:0];
    if (!skip && w) for (int i = 0; i < size; i++) ref_mem[10'(a + i)] = d[8*i +: 8];

    @(negedge clk);
    req = 1'b1; we = w; sel = s; sign = sg; addr = a; wdata = d;
    #1 check("busy_start", busy, 1'b1);
    got_done = 1'b0;
    for (int cyc = 1; cyc <= exp_done + 4 && !got_done; cyc++) begin
      @(negedge clk);
      if (cyc <= nb) begin
        ebe = '0; ewd = '0; mask = '0;
        for (int k = 0; k < BB; k++) begin
          idx = (cyc - 1) * BB + k;
          if (idx < size) begin
            ebe[k] = 1'b1;
            mask[8*k +: 8] = 8'hFF;
            ewd[8*k +: 8] = d[8*idx +: 8];
          end
        end
        check("beat_addr", m_addr, a + (cyc - 1) * BB);
        check("beat_we", m_we, w);
        check("beat_be", m_be, ebe);
        if (w) check("beat_wdata", m_wdata & mask, ewd);
      end else begin
        check("no_beat", m_be, '0);
      end
      check("done_cycle", done, cyc == exp_done);
      check("busy", busy, !done);
      if (done) begin
        got_done = 1'b1;
        if (!w) check("rdata", rdata, exp_r);
        check("err", err, mis);
        check("bus_addr_zero", m_addr, 0);
        check("bus_we_zero", m_we, 0);
        check("bus_wdata_zero", m_wdata, 0);
      end
    end
    if (!got_done) check("timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_done", done, 0);
    end
  endtask

  // One access on instance 2 (single beat, since sizes <= BEAT_BYTES).
  task automatic access2(input logic w, input logic [1:0] s, input logic sg,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_r);
    int size, exp_done;
    logic got_done;
    logic [3:0] ebe;
    size     = size_of(s);
    ebe      = 4'((1 << size) - 1);
    exp_done = w ? 2 : 1 + RL2 + 1;
    @(negedge clk);
    req2 = 1'b1; we2 = w; sel2 = s; sign2 = sg; addr2 = a; wdata2 = d;
    got_done = 1'b0;
    for (int cyc = 1; cyc <= exp_done + 4 && !got_done; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        check("b4_addr", m_addr2, a);
        check("b4_be", m_be2, ebe);
        check("b4_we", m_we2, w);
        if (w) check("b4_wdata", m_wdata2 & {{8{ebe[3]}}, {8{ebe[2]}}, {8{ebe[1]}}, {8{ebe[0]}}},
                     d & {{8{ebe[3]}}, {8{ebe[2]}}, {8{ebe[1]}}, {8{ebe[0]}}});
      end
      if (done2) begin
        got_done = 1'b1;
        check("b4_done_cycle", cyc, exp_done);
        if (!w) check("b4_rdata", rdata2, exp_r);
        check("b4_bus_addr_zero", m_addr2, 0);
        check("b4_bus_be_zero", m_be2, 0);
        check("b4_bus_wdata_zero", m_wdata2, 0);
      end
    end
    if (!got_done) check("b4_timeout", 0, 1);
    req2 = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i]  = 8'($urandom);
      bus_mem[i]  = ref_mem[i];
      bus_mem2[i] = 8'($urandom);
    end
    ref_mem[10'h100] = 8'h80; ref_mem[10'h101] = 8'h7F;
    ref_mem[10'h102] = 8'h01; ref_mem[10'h103] = 8'h02;
    ref_mem[10'h104] = 8'h55;
    for (int i = 'h100; i <= 'h104; i++) bus_mem[i] = ref_mem[i];
    for (int s = 0; s <= RL; s++) begin pv[s] = 1'b0; pa[s] = '0; end
    for (int s = 0; s <= RL2; s++) begin pv2[s] = 1'b0; pa2[s] = '0; end

    rst = 1'b0;
    req = 0; we = 0; sel = 0; sign = 0; addr = 0; wdata = 0;
    req2 = 0; we2 = 0; sel2 = 0; sign2 = 0; addr2 = 0; wdata2 = 0;
    #1;
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 0);
    check("rst_err", err, 0);
    check("rst_addr", m_addr, 0);
    check("rst_be", m_be, 0);
    check("rst_wdata", m_wdata, 0);
    req = 1'b1;
    #1 check("rst_busy_follows_req", busy, 1);
    req = 1'b0;
    #1 check("rst_busy_low", busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Directed: sign/zero extension, word assembly, misaligned word.
    access(1'b0, 2'd0, 1'b1, 32'h100, 32'h0);   // lb  -> FFFFFF80, done cycle 4
    idle(1);
    access(1'b0, 2'd0, 1'b0, 32'h100, 32'h0);   // lbu -> 00000080
    idle(1);
    access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);   // lw  -> 02017F80, done cycle 7
    idle(1);
    access(1'b0, 2'd2, 1'b0, 32'h101, 32'h0);   // misaligned lw
    idle(1);
    access(1'b0, 2'd1, 1'b1, 32'h100, 32'h0);   // lh  -> 00007F80
    idle(1);
    access(1'b0, 2'd3, 1'b0, 32'h100, 32'h0);   // reserved -> 0, done cycle 1
    idle(1);

    // Back-to-back sw then lw: busy low only in the done cycle between them.
    access(1'b1, 2'd2, 1'b0, 32'h180, 32'hDEADBEEF);
    check("b2b_gap_busy", busy, 0);
    access(1'b0, 2'd2, 1'b0, 32'h180, 32'h0);
    idle(1);

    // Reset in cycle 2 of a lw.
    @(negedge clk);
    req = 1'b1; we = 1'b0; sel = 2'd2; sign = 1'b0; addr = 32'h100;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_beat", m_addr, 32'h101);
    rst = 1'b0;
    #1;
    check("midrst_done", done, 0);
    check("midrst_addr", m_addr, 0);
    check("midrst_be", m_be, 0);
    check("midrst_rdata", rdata, 0);
    check("midrst_busy", busy, 1);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle(8);
    access(1'b0, 2'd0, 1'b1, 32'h101, 32'h0);   // lb after reset -> 0000007F
    idle(1);

    // Randomized mix against the reference memory.
    for (int n = 0; n < 60; n++) begin
      access(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
             32'($urandom_range('h100, 'h3E0)), $urandom);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 2));
    end
    idle(2);

    // Instance 2: wide beats.
    access2(1'b1, 2'd1, 1'b0, 32'h200, 32'h0000_1234, 32'h0);
    access2(1'b0, 2'd1, 1'b1, 32'h200, 32'h0, 32'h0000_1234);
    access2(1'b0, 2'd0, 1'b1, 32'h201, 32'h0, 32'h0000_0012);
    access2(1'b1, 2'd2, 1'b0, 32'h204, 32'h89AB_CDEF, 32'h0);
    access2(1'b0, 2'd2, 1'b0, 32'h204, 32'h0, 32'h89AB_CDEF);
    access2(1'b0, 2'd1, 1'b1, 32'h206, 32'h0, 32'hFFFF_89AB);
    access2(1'b0, 2'd0, 1'b0, 32'h207, 32'h0, 32'h0000_0089);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
